// File: rtl/neander_x_pkg.sv
// Shared opcode constants and controller state type for the NEANDER-X
// multiply/divide sequencing logic.
package neander_x_pkg;

  localparam logic [3:0] ALU_MUL = 4'b1001;
  localparam logic [3:0] ALU_DIV = 4'b1010;
  localparam logic [3:0] ALU_MOD = 4'b1011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/neander_x_muldiv_ctrl.sv
// Sequences one MUL/DIV/MOD through the external multiplier or divider,
// latches the result bytes and carry, and aborts if the unit never answers.
module neander_x_muldiv_ctrl
  import neander_x_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic [3:0] alu_op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       busy,
  output logic       done,
  output logic       mul_start,
  output logic       div_start,
  output logic [7:0] op_a,
  output logic [7:0] op_b,
  input  logic       mul_done,
  input  logic       div_done,
  input  logic [7:0] mul_product_low,
  input  logic [7:0] mul_product_high,
  input  logic [7:0] div_quotient,
  input  logic [7:0] div_remainder,
  output logic [7:0] res_lo,
  output logic [7:0] res_hi,
  output logic       flag_c,
  output logic       timeout
);

  localparam logic [7:0] TO_LIM = TIMEOUT_CYCLES[7:0];

  state_e     state_q, state_d;
  logic [3:0] op_q, op_d;
  logic [7:0] op_a_q, op_a_d;
  logic [7:0] op_b_q, op_b_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] res_lo_q, res_lo_d;
  logic [7:0] res_hi_q, res_hi_d;
  logic       flag_c_q, flag_c_d;
  logic       timeout_q, timeout_d;

  logic       op_ok;
  logic       is_mul;
  logic       unit_done;

  assign op_ok     = (alu_op == ALU_MUL) || (alu_op == ALU_DIV) || (alu_op == ALU_MOD);
  assign is_mul    = (op_q == ALU_MUL);
  assign unit_done = is_mul ? mul_done : div_done;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    cnt_d     = cnt_q;
    res_lo_d  = res_lo_q;
    res_hi_d  = res_hi_q;
    flag_c_d  = flag_c_q;
    timeout_d = timeout_q;
    mul_start = 1'b0;
    div_start = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req && op_ok) begin
          op_d   = alu_op;
          op_a_d = a;
          op_b_d = b;
          // Divide by zero is resolved here without ever starting the divider
          if (alu_op != ALU_MUL && b == 8'h00) begin
            res_lo_d  = (alu_op == ALU_DIV) ? 8'hFF : a;
            res_hi_d  = (alu_op == ALU_DIV) ? a : 8'hFF;
            flag_c_d  = 1'b1;
            timeout_d = 1'b0;
            state_d   = ST_DONE;
          end else begin
            state_d = ST_START;
          end
        end
      end

      ST_START: begin
        mul_start = is_mul;
        div_start = !is_mul;
        cnt_d     = 8'h00;
        state_d   = ST_WAIT;
      end

      ST_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        // A strobe on the final counted cycle still wins over the abort
        if (unit_done) begin
          timeout_d = 1'b0;
          state_d   = ST_DONE;
          case (op_q)
            ALU_MUL: begin
              res_lo_d = mul_product_low;
              res_hi_d = mul_product_high;
              flag_c_d = |mul_product_high;
            end
            ALU_DIV: begin
              res_lo_d = div_quotient;
              res_hi_d = div_remainder;
              flag_c_d = 1'b0;
            end
            default: begin
              res_lo_d = div_remainder;
              res_hi_d = div_quotient;
              flag_c_d = 1'b0;
            end
          endcase
        end else if (cnt_q + 8'd1 == TO_LIM) begin
          res_lo_d  = 8'h00;
          res_hi_d  = 8'h00;
          flag_c_d  = 1'b0;
          timeout_d = 1'b1;
          state_d   = ST_DONE;
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      op_q      <= 4'h0;
      op_a_q    <= 8'h00;
      op_b_q    <= 8'h00;
      cnt_q     <= 8'h00;
      res_lo_q  <= 8'h00;
      res_hi_q  <= 8'h00;
      flag_c_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      cnt_q     <= cnt_d;
      res_lo_q  <= res_lo_d;
      res_hi_q  <= res_hi_d;
      flag_c_q  <= flag_c_d;
      timeout_q <= timeout_d;
    end
  end

  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_DONE);
  assign op_a    = op_a_q;
  assign op_b    = op_b_q;
  assign res_lo  = res_lo_q;
  assign res_hi  = res_hi_q;
  assign flag_c  = flag_c_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_neander_x_muldiv_ctrl.sv
// Directed bench for the multiply/divide controller: vector table plus
// hand sequences for back-to-back requests, ignored opcodes and reset abort.
module tb_neander_x_muldiv_ctrl;
  import neander_x_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       req;
  logic [3:0] alu_op;
  logic [7:0] a, b;
  logic       busy, done, mul_start, div_start;
  logic [7:0] op_a, op_b;
  logic       mul_done, div_done;
  logic [7:0] mul_product_low, mul_product_high, div_quotient, div_remainder;
  logic [7:0] res_lo, res_hi;
  logic       flag_c, timeout;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  neander_x_muldiv_ctrl #(.TIMEOUT_CYCLES(12)) dut (
    .clk(clk), .reset(reset), .req(req), .alu_op(alu_op), .a(a), .b(b),
    .busy(busy), .done(done), .mul_start(mul_start), .div_start(div_start),
    .op_a(op_a), .op_b(op_b), .mul_done(mul_done), .div_done(div_done),
    .mul_product_low(mul_product_low), .mul_product_high(mul_product_high),
    .div_quotient(div_quotient), .div_remainder(div_remainder),
    .res_lo(res_lo), .res_hi(res_hi), .flag_c(flag_c), .timeout(timeout)
  );

  // k: cycles after start at which the unit strobes (0 = never)
  typedef struct {
    logic [3:0] op;
    logic [7:0] a, b;
    int         k;
    logic       strb_div;
    logic       hold_req;
    logic [7:0] u_lo, u_hi;
    logic [7:0] e_lo, e_hi;
    logic       e_c, e_to;
    int         e_lat, e_ms, e_ds;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat = -1;
    int ms = 0;
    int ds = 0;
    string nm;
    nm = $sformatf("v%0d", idx);
    @(negedge clk);
    req = 1'b1; alu_op = v.op; a = v.a; b = v.b;
    mul_product_low = v.u_lo; mul_product_high = v.u_hi;
    div_quotient = v.u_lo; div_remainder = v.u_hi;
    @(negedge clk);
    a = 8'hC3; b = 8'h3C;
    if (v.hold_req) begin
      alu_op = ALU_DIV; b = 8'h00;
    end else begin
      req = 1'b0; alu_op = 4'h0;
    end
    for (int c = 1; c <= 40; c++) begin
      if (c > 1) @(negedge clk);
      mul_done = 1'b0; div_done = 1'b0;
      ms += int'(mul_start);
      ds += int'(div_start);
      if (done) begin
        lat = c;
        req = 1'b0;
        break;
      end
      if (v.k > 0 && c == 1 + v.k) begin
        if (v.strb_div) div_done = 1'b1;
        else mul_done = 1'b1;
      end
    end
    req = 1'b0;
    chk({nm, " latency"}, lat, v.e_lat);
    chk({nm, " mul_start count"}, ms, v.e_ms);
    chk({nm, " div_start count"}, ds, v.e_ds);
    chk({nm, " res_lo"}, int'(res_lo), int'(v.e_lo));
    chk({nm, " res_hi"}, int'(res_hi), int'(v.e_hi));
    chk({nm, " flag_c"}, int'(flag_c), int'(v.e_c));
    chk({nm, " timeout"}, int'(timeout), int'(v.e_to));
    chk({nm, " busy at done"}, int'(busy), 1);
    chk({nm, " op_a"}, int'(op_a), int'(v.a));
    chk({nm, " op_b"}, int'(op_b), int'(v.b));
    @(negedge clk);
    chk({nm, " done after"}, int'(done), 0);
    chk({nm, " busy after"}, int'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //           op       a      b      k  sd hr u_lo   u_hi   e_lo   e_hi   c  to lat ms ds
    vecs[0]  = '{ALU_MUL, 8'h12, 8'h34, 8, 0, 0, 8'hA8, 8'h03, 8'hA8, 8'h03, 1, 0, 10, 1, 0};
    vecs[1]  = '{ALU_DIV, 8'd100, 8'd7, 5, 1, 0, 8'd14, 8'd2, 8'd14, 8'd2, 0, 0, 7, 0, 1};
    vecs[2]  = '{ALU_MOD, 8'd100, 8'd7, 3, 1, 0, 8'd14, 8'd2, 8'd2, 8'd14, 0, 0, 5, 0, 1};
    vecs[3]  = '{ALU_DIV, 8'h55, 8'h00, 0, 1, 0, 8'h11, 8'h22, 8'hFF, 8'h55, 1, 0, 1, 0, 0};
    vecs[4]  = '{ALU_MOD, 8'h55, 8'h00, 0, 1, 0, 8'h11, 8'h22, 8'h55, 8'hFF, 1, 0, 1, 0, 0};
    vecs[5]  = '{ALU_MUL, 8'h10, 8'h0F, 0, 0, 0, 8'hF0, 8'h00, 8'h00, 8'h00, 0, 1, 14, 1, 0};
    vecs[6]  = '{ALU_MUL, 8'h10, 8'h0F, 12, 0, 0, 8'hF0, 8'h00, 8'hF0, 8'h00, 0, 0, 14, 1, 0};
    vecs[7]  = '{ALU_MUL, 8'h10, 8'h0F, 2, 1, 0, 8'hF0, 8'h01, 8'h00, 8'h00, 0, 1, 14, 1, 0};
    vecs[8]  = '{ALU_MUL, 8'hFF, 8'hFF, 1, 0, 0, 8'h01, 8'hFE, 8'h01, 8'hFE, 1, 0, 3, 1, 0};
    vecs[9]  = '{ALU_DIV, 8'd7, 8'd100, 1, 1, 0, 8'h00, 8'h07, 8'h00, 8'h07, 0, 0, 3, 0, 1};
    vecs[10] = '{ALU_MUL, 8'h07, 8'h00, 2, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 4, 1, 0};
    vecs[11] = '{ALU_MUL, 8'h03, 8'h05, 4, 0, 1, 8'h0F, 8'h00, 8'h0F, 8'h00, 0, 0, 6, 1, 0};

    reset = 1'b1; req = 1'b0; alu_op = ALU_MUL; a = 8'h5A; b = 8'hA5;
    mul_done = 1'b0; div_done = 1'b0;
    mul_product_low = 8'h00; mul_product_high = 8'h00;
    div_quotient = 8'h00; div_remainder = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst mul_start", int'(mul_start), 0);
    chk("rst div_start", int'(div_start), 0);
    chk("rst res_lo", int'(res_lo), 0);
    chk("rst res_hi", int'(res_hi), 0);
    chk("rst flag_c", int'(flag_c), 0);
    chk("rst timeout", int'(timeout), 0);
    chk("rst op_a", int'(op_a), 0);
    chk("rst op_b", int'(op_b), 0);
    reset = 1'b0; alu_op = 4'h0;

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // Unsupported opcode: nothing starts, previous results hold
    @(negedge clk);
    req = 1'b1; alu_op = 4'b0000; a = 8'h09; b = 8'h09;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("badop busy", int'(busy), 0);
      chk("badop done", int'(done), 0);
    end
    req = 1'b0;
    chk("badop res_lo hold", int'(res_lo), 8'h0F);
    chk("badop op_a hold", int'(op_a), 8'h03);

    // req held through DONE: the next request is taken one IDLE cycle later
    @(negedge clk);
    req = 1'b1; alu_op = ALU_DIV; a = 8'h20; b = 8'h00;
    @(negedge clk);
    chk("b2b done1", int'(done), 1);
    chk("b2b res_lo1", int'(res_lo), 8'hFF);
    chk("b2b res_hi1", int'(res_hi), 8'h20);
    @(negedge clk);
    chk("b2b gap done", int'(done), 0);
    chk("b2b gap busy", int'(busy), 0);
    alu_op = ALU_MOD; a = 8'h30;
    @(negedge clk);
    req = 1'b0;
    chk("b2b done2", int'(done), 1);
    chk("b2b res_lo2", int'(res_lo), 8'h30);
    chk("b2b res_hi2", int'(res_hi), 8'hFF);
    @(negedge clk);
    chk("b2b idle", int'(busy), 0);

    // Reset mid-WAIT, then a stale multiplier strobe
    req = 1'b1; alu_op = ALU_MUL; a = 8'h21; b = 8'h02;
    @(negedge clk);
    req = 1'b0; alu_op = 4'h0;
    repeat (3) @(negedge clk);
    chk("abort busy before", int'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; mul_done = 1'b1;
    mul_product_low = 8'h42; mul_product_high = 8'h01;
    @(negedge clk);
    mul_done = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("abort done", int'(done), 0);
      chk("abort busy", int'(busy), 0);
      @(negedge clk);
    end
    chk("abort res_lo", int'(res_lo), 0);
    chk("abort res_hi", int'(res_hi), 0);
    chk("abort flag_c", int'(flag_c), 0);
    chk("abort timeout", int'(timeout), 0);
    chk("abort op_a", int'(op_a), 0);
    chk("abort op_b", int'(op_b), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
